// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter: shares a single-port instruction memory between CPU fetch and a burst loader
module instr_mem_arbiter #(
  parameter int MEM_WORDS  = 32,
  parameter int IDX_W      = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_req_i,
  input  logic [31:0]      fetch_addr_i,
  output logic             fetch_gnt_o,
  output logic             fetch_rvalid_o,
  output logic [31:0]      fetch_rdata_o,
  output logic             fetch_err_o,
  input  logic             ld_req_i,
  input  logic [31:0]      ld_addr_i,
  input  logic [31:0]      ld_data_i,
  input  logic             ld_last_i,
  output logic             ld_gnt_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [IDX_W-1:0] mem_idx_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state, state_nx;
  logic [SW-1:0] starve;
  logic rvalid, err, f_bad, l_bad, ld_win, f_acc, l_acc;
  assign f_bad = |fetch_addr_i[1:0] || fetch_addr_i[31:2] >= 30'(MEM_WORDS);
  assign l_bad = |ld_addr_i[1:0] || ld_addr_i[31:2] >= 30'(MEM_WORDS);
  // Grants are gated by reset so every output reads 0 the moment reset asserts
  always_comb begin
    ld_win = state == LOAD ? ld_req_i : ld_req_i && (!fetch_req_i || starve == SMAX);
    ld_gnt_o = rst_i && ld_win;
    fetch_gnt_o = rst_i && state == IDLE && fetch_req_i && !ld_win;
    f_acc = fetch_gnt_o && !f_bad;
    l_acc = ld_gnt_o && !l_bad;
    mem_en_o = f_acc || l_acc;
    mem_we_o = l_acc;
    mem_idx_o = l_acc ? ld_addr_i[IDX_W+1:2] : f_acc ? fetch_addr_i[IDX_W+1:2] : '0;
    mem_wdata_o = l_acc ? ld_data_i : '0;
    state_nx = ld_gnt_o ? (ld_last_i ? IDLE : LOAD) : state;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      starve <= '0;
      rvalid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      starve <= ld_gnt_o ? '0 : (ld_req_i && starve != SMAX) ? starve + 1'b1 : starve;
      rvalid <= fetch_gnt_o;
      err <= fetch_gnt_o && f_bad;
    end
  end
  assign fetch_rvalid_o = rvalid;
  assign fetch_err_o = err;
  assign fetch_rdata_o = rvalid && !err ? mem_rdata_i : '0;
  assign busy_o = state == LOAD;
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// tb_instr_mem_arbiter: random + directed stimulus checked every cycle against a behavioural model
module tb_instr_mem_arbiter;
  localparam int WORDS = 32;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic fetch_req_i = 1'b0, ld_req_i = 1'b0, ld_last_i = 1'b0;
  logic [31:0] fetch_addr_i = '0, ld_addr_i = '0, ld_data_i = '0, mem_rdata_i = '0;
  logic fetch_gnt_o, fetch_rvalid_o, fetch_err_o, ld_gnt_o, mem_en_o, mem_we_o, busy_o;
  logic [31:0] fetch_rdata_o, mem_wdata_o;
  logic [4:0] mem_idx_o;
  logic [31:0] mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  int checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  instr_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_err_o(fetch_err_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
    .ld_gnt_o(ld_gnt_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_idx_o(mem_idx_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  // Synchronous single-port memory attached to the DUT
  always @(posedge clk_i)
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_idx_o] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_idx_o];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port this cycle, from the arbitration rules
  bit m_load;
  int m_miss;
  logic exp_rv, exp_err;
  logic [31:0] exp_rd;
  always @(negedge clk_i) begin : model
    bit fbad, lbad, fg, lg, e_en;
    if (!rst_i) begin
      chk("rst_fetch_gnt", fetch_gnt_o, 0);
      chk("rst_ld_gnt", ld_gnt_o, 0);
      chk("rst_rvalid", fetch_rvalid_o, 0);
      chk("rst_rdata", fetch_rdata_o, 0);
      chk("rst_err", fetch_err_o, 0);
      chk("rst_mem_en", mem_en_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_busy", busy_o, 0);
      m_load = 0; m_miss = 0; exp_rv = 0; exp_err = 0; exp_rd = 0;
    end else begin
      fbad = fetch_addr_i % 4 != 0 || fetch_addr_i >= 4 * WORDS;
      lbad = ld_addr_i % 4 != 0 || ld_addr_i >= 4 * WORDS;
      if (m_load) begin lg = ld_req_i; fg = 0; end
      else if (ld_req_i && fetch_req_i) begin lg = m_miss == 4; fg = !lg; end
      else begin lg = ld_req_i; fg = fetch_req_i; end
      e_en = (fg && !fbad) || (lg && !lbad);
      chk("fetch_gnt", fetch_gnt_o, fg);
      chk("ld_gnt", ld_gnt_o, lg);
      chk("busy", busy_o, m_load);
      chk("rvalid", fetch_rvalid_o, exp_rv);
      chk("err", fetch_err_o, exp_err);
      chk("rdata", fetch_rdata_o, exp_rd);
      chk("mem_en", mem_en_o, e_en);
      chk("mem_we", mem_we_o, lg && !lbad);
      if (e_en || !(fg || lg)) begin
        chk("mem_idx", mem_idx_o, !e_en ? 0 : lg ? ld_addr_i / 4 : fetch_addr_i / 4);
        chk("mem_wdata", mem_wdata_o, e_en && lg ? ld_data_i : 0);
      end
      exp_rv = fg;
      exp_err = fg && fbad;
      exp_rd = fg && !fbad ? ref_mem[fetch_addr_i / 4] : 0;
      if (lg) begin
        m_miss = 0;
        if (!lbad) ref_mem[ld_addr_i / 4] = ld_data_i;
        m_load = !ld_last_i;
      end else if (ld_req_i && m_miss < 4) m_miss++;
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [31:0] la, input logic [31:0] ld, input logic ll);
    @(posedge clk_i); #1;
    fetch_req_i = fr; fetch_addr_i = fa;
    ld_req_i = lr; ld_addr_i = la; ld_data_i = ld; ld_last_i = ll;
  endtask

  initial begin
    int n;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    // Back-to-back fetches, then misaligned and out-of-range
    drive(1, 32'h0, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_gnt0", fetch_gnt_o, 1); chk("d_idx0", mem_idx_o, 0);
    drive(1, 32'h4, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_idx1", mem_idx_o, 1); chk("d_rd0", fetch_rdata_o, 32'h11); chk("d_rv0", fetch_rvalid_o, 1);
    drive(1, 32'h8, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_idx2", mem_idx_o, 2); chk("d_rd1", fetch_rdata_o, 32'h22);
    drive(1, 32'h6, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_mis_gnt", fetch_gnt_o, 1); chk("d_mis_en", mem_en_o, 0); chk("d_rd2", fetch_rdata_o, 32'h33);
    drive(1, 32'h80, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_oor_en", mem_en_o, 0); chk("d_mis_err", fetch_err_o, 1); chk("d_mis_rd", fetch_rdata_o, 0);
    drive(0, 0, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_oor_err", fetch_err_o, 1); chk("d_oor_rv", fetch_rvalid_o, 1);
    // Starvation then a locked 3-beat burst with fetch held high
    n = 0;
    drive(1, 32'hC, 1, 32'h0, 32'hA, 0); @(negedge clk_i);
    while (!ld_gnt_o && n < 20) begin
      n++;
      drive(1, 32'hC, 1, 32'h0, 32'hA, 0); @(negedge clk_i);
    end
    chk("d_starve_losses", n, 4);
    drive(1, 32'hC, 1, 32'h4, 32'hB, 0); @(negedge clk_i);
    chk("d_b2_fgnt", fetch_gnt_o, 0); chk("d_b2_busy", busy_o, 1); chk("d_b2_lgnt", ld_gnt_o, 1);
    drive(1, 32'hC, 1, 32'h8, 32'hC, 1); @(negedge clk_i);
    chk("d_b3_fgnt", fetch_gnt_o, 0); chk("d_b3_busy", busy_o, 1);
    drive(1, 32'hC, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_resume_fgnt", fetch_gnt_o, 1); chk("d_resume_busy", busy_o, 0);
    chk("d_mem0", mem[0], 32'hA); chk("d_mem1", mem[1], 32'hB); chk("d_mem2", mem[2], 32'hC);
    // Out-of-range beat mid-burst is dropped but the burst continues
    drive(0, 0, 1, 32'h10, 32'h1, 0); @(negedge clk_i);
    chk("d_bad_b1_we", mem_we_o, 1);
    drive(0, 0, 1, 32'h100, 32'h2, 0); @(negedge clk_i);
    chk("d_bad_gnt", ld_gnt_o, 1); chk("d_bad_we", mem_we_o, 0); chk("d_bad_busy", busy_o, 1);
    drive(0, 0, 1, 32'h14, 32'h3, 1); @(negedge clk_i);
    chk("d_bad_b3_we", mem_we_o, 1);
    drive(0, 0, 0, 0, 0, 0); @(negedge clk_i);
    chk("d_bad_end_busy", busy_o, 0); chk("d_bad_mem5", mem[5], 32'h3);
    // Reset asserted mid-burst
    drive(0, 0, 1, 32'h20, 32'h5, 0); @(negedge clk_i);
    chk("d_rst_b1", ld_gnt_o, 1);
    drive(0, 0, 1, 32'h24, 32'h6, 0); rst_i = 1'b0; @(negedge clk_i);
    chk("d_rst_busy", busy_o, 0); chk("d_rst_lgnt", ld_gnt_o, 0);
    drive(1, 32'h0, 0, 0, 0, 0); rst_i = 1'b1; @(negedge clk_i);
    chk("d_post_rst_fgnt", fetch_gnt_o, 1); chk("d_post_rst_busy", busy_o, 0);
    chk("d_rst_mem8", mem[8], 32'h5);
    // Randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] fa, la;
      fa = $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, WORDS - 1) * 4);
      la = $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, WORDS - 1) * 4);
      drive(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 2) == 0), la, $urandom,
            1'($urandom_range(0, 3) == 0));
      rst_i = $urandom_range(0, 299) != 0;
    end
    drive(0, 0, 0, 0, 0, 0); rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < WORDS; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
